bcd2bin_seq: RTL and testbench
==============================

// Module: bcd2bin_seq
// PURPOSE
//  Sequential packed-BCD to binary converter (reverse double-dabble); inverse of the
//  binary-to-BCD path feeding the LCD1602 digit formatter. Converts a DIGITS-digit BCD
//  word (e.g. a user-entered lux threshold) into an unsigned binary value for comparison
//  with BH1750 readings. One shift per clock; start/busy/done handshake; flags for bad digits and overflow.
// PARAMETERS
//  DIGITS   5    number of BCD digits on i_bcd (input width 4*DIGITS)
//  BIN_W    16   width of o_binary; results >= 2**BIN_W flag overflow
// PORTS
//  i_clk     in   1          system clock, all logic on rising edge
//  i_rst     in   1          synchronous reset, active-high
//  i_start   in   1          level; sampled only in IDLE, begins a conversion
//  i_bcd     in   4*DIGITS   packed BCD, digit 0 in [3:0]; captured on accepted start
//  o_busy    out  1          high while a conversion is in progress
//  o_done    out  1          one-cycle pulse: o_binary/o_err/o_ovf updated this cycle
//  o_binary  out  BIN_W      converted value; held until next o_done
//  o_err     out  1          last conversion had a digit > 9
//  o_ovf     out  1          last conversion result exceeded 2**BIN_W-1
// BEHAVIOUR
//  Reset (sync, i_rst=1 at edge): state=IDLE; o_busy=0, o_done=0, o_binary=0, o_err=0,
//   o_ovf=0; shift count and work regs cleared. Reset mid-conversion aborts it, no o_done.
//  States: IDLE -> (i_start) LOAD-check -> SHIFT (x 4*DIGITS) -> DONE -> IDLE.
//  Edge 0 (IDLE, i_start=1): capture i_bcd into bcd reg, clear bin reg (4*DIGITS bits),
//   count=0, o_busy=1. Any captured digit > 9 -> go to DONE on edge 1 with err path.
//  SHIFT, edges 1..4*DIGITS: {bcd,bin} >>= 1 (LSB of bcd enters MSB of bin); then each
//   bcd digit >= 8 gets -3 (mod 16). count++; after shift 4*DIGITS go to DONE.
//  DONE edge (edge 4*DIGITS+1 normal, edge 1 err path): o_done=1 for one cycle,
//   o_busy=0, state=IDLE.
//   err path: o_binary=0, o_err=1, o_ovf=0.
//   normal: if bin[4*DIGITS-1:BIN_W] != 0 -> o_binary=all ones (saturate), o_ovf=1;
//   else o_binary=bin[BIN_W-1:0], o_ovf=0; o_err=0.
//  Latency: start sampled edge 0 -> o_done high after edge 4*DIGITS+1 (21 at defaults),
//   low again after next edge. Back-to-back: start held high -> new capture on edge
//   after DONE (IDLE), i.e. one conversion per 4*DIGITS+2 cycles.
//  i_start while busy or in DONE cycle: ignored; i_bcd changes while busy: ignored.
//  Flags are sticky only until the next o_done; never both o_err and o_ovf set.
//  If 4*DIGITS <= BIN_W, overflow is impossible and o_ovf stays 0.
//  Arithmetic purely shift/subtract; no multipliers. All outputs registered.
// TESTING
//  i_bcd=20'h12345, start -> o_done 21 edges later, o_binary=16'h3039, err=0, ovf=0.
//  i_bcd=20'h65535 -> o_binary=16'hFFFF, ovf=0; i_bcd=20'h65536 -> 16'hFFFF, ovf=1.
//  i_bcd=20'h99999 -> o_ovf=1, o_binary=16'hFFFF; i_bcd=0 -> o_binary=0, flags 0.
//  i_bcd=20'h1A345 -> o_done after 1 edge, o_err=1, o_binary=0, o_busy 1 cycle only.
//  Start re-pulsed at edge 5 of a busy conversion -> ignored, single o_done, result intact.
//  i_rst at edge 10 mid-conversion -> all outputs 0 next cycle, no o_done; fresh start works.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// -----------------------------------------------------------------------------
// bcd2bin_seq
//   Sequential packed-BCD to binary converter (reverse double-dabble).
//   One shift per clock. A conversion is started with i_start and signalled
//   complete with a one-cycle o_done pulse.
//
//   Ports
//     i_clk     : system clock, rising edge
//     i_rst     : synchronous reset, active-high
//     i_start   : level, sampled only while idle; begins a conversion
//     i_bcd     : packed BCD, digit 0 in [3:0]; captured on an accepted start
//     o_busy    : high while a conversion is in progress
//     o_done    : one-cycle pulse when o_binary/o_err/o_ovf are updated
//     o_binary  : converted value, held until the next o_done
//     o_err     : last conversion contained a digit > 9
//     o_ovf     : last conversion exceeded 2**BIN_W-1 (o_binary saturated)
// -----------------------------------------------------------------------------
module bcd2bin_seq #(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [4*DIGITS-1:0]   i_bcd,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [BIN_W-1:0]      o_binary,
    output logic                  o_err,
    output logic                  o_ovf
);

    localparam int WORK_W = 4 * DIGITS;
    // Working value widened so the overflow test is valid even when the
    // BCD range fits entirely inside BIN_W (overflow then never fires).
    localparam int EXT_W  = (WORK_W > BIN_W) ? WORK_W : BIN_W;
    localparam int CNT_W  = $clog2(WORK_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q,  state_d;
    logic [WORK_W-1:0] bcd_q,    bcd_d;
    logic [WORK_W-1:0] bin_q,    bin_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [BIN_W-1:0]  binary_q, binary_d;
    logic              err_q,    err_d;
    logic              ovf_q,    ovf_d;

    function automatic logic has_bad_digit(input logic [WORK_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // One reverse double-dabble step: shift {bcd,bin} right, then pull every
    // BCD digit that now reads >= 8 back by 3 so it stays a valid decimal digit
    // after halving.
    function automatic logic [2*WORK_W-1:0] shift_step(input logic [WORK_W-1:0] bcd,
                                                       input logic [WORK_W-1:0] bin);
        logic [2*WORK_W-1:0] w;
        logic [3:0]          d;
        w = {bcd, bin} >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = w[WORK_W + 4*i +: 4];
            if (d >= 4'd8) w[WORK_W + 4*i +: 4] = d - 4'd3;
        end
        return w;
    endfunction

    function automatic logic is_over(input logic [EXT_W-1:0] v);
        return (v >> BIN_W) != '0;
    endfunction

    function automatic logic [BIN_W-1:0] sat_bin(input logic [EXT_W-1:0] v);
        return is_over(v) ? {BIN_W{1'b1}} : v[BIN_W-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        binary_d = binary_q;
        err_d    = err_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    bcd_d   = i_bcd;
                    bin_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Bad digits short-circuit straight to a completed error result.
                if (has_bad_digit(bcd_q)) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    binary_d = '0;
                    err_d    = 1'b1;
                    ovf_d    = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    {bcd_d, bin_d} = shift_step(bcd_q, bin_q);
                    count_d        = CNT_W'(1);
                    state_d        = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = shift_step(bcd_q, bin_q);
                count_d        = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WORK_W - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                binary_d = sat_bin(EXT_W'(bin_q));
                ovf_d    = is_over(EXT_W'(bin_q));
                err_d    = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            bcd_q    <= '0;
            bin_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            binary_q <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            binary_q <= binary_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_binary = binary_q;
    assign o_err    = err_q;
    assign o_ovf    = ovf_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd2bin_seq
//   Directed self-checking bench for bcd2bin_seq at default parameters
//   (5 digits, 16-bit result). Inputs driven on the falling edge or #1 after
//   the rising edge; outputs sampled #1 after the rising edge.
// -----------------------------------------------------------------------------
module tb_bcd2bin_seq;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [19:0] i_bcd;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_binary;
    logic        o_err;
    logic        o_ovf;

    int checks   = 0;
    int failures = 0;

    bcd2bin_seq #(.DIGITS(5), .BIN_W(16)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_bcd    (i_bcd),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_binary (o_binary),
        .o_err    (o_err),
        .o_ovf    (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Starts one conversion and waits (bounded) for o_done. edges = number of
    // rising edges after the capturing edge until o_done was seen.
    task automatic run_conv(input logic [19:0] bcd, output int edges,
                            output logic [15:0] bin, output logic err,
                            output logic ovf, output logic busy0,
                            output logic busy_done);
        @(negedge i_clk);
        i_start = 1'b1;
        i_bcd   = bcd;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        busy0 = o_busy;
        edges = 0;
        while (!o_done && edges < 100) begin
            @(posedge i_clk);
            #1;
            edges++;
        end
        bin       = o_binary;
        err       = o_err;
        ovf       = o_ovf;
        busy_done = o_busy;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b0; i_bcd = '0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if ({o_busy, o_done, o_binary, o_err, o_ovf} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b bin=%h err=%b ovf=%b, want all 0",
                     o_busy, o_done, o_binary, o_err, o_ovf);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_convert();
        logic [19:0] vin  [7] = '{20'h12345, 20'h00000, 20'h65535, 20'h65536,
                                  20'h99999, 20'h00255, 20'h40000};
        logic [15:0] vexp [7] = '{16'h3039, 16'h0000, 16'hFFFF, 16'hFFFF,
                                  16'hFFFF, 16'h00FF, 16'h9C40};
        logic        vovf [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int edges; logic [15:0] bin; logic err, ovf, b0, bd;
        for (int i = 0; i < 7; i++) begin
            run_conv(vin[i], edges, bin, err, ovf, b0, bd);
            checks++;
            if (edges !== 21 || b0 !== 1'b1 || bd !== 1'b0) begin
                failures++;
                $display("FAIL conv_timing[%h]: got edges=%0d busy0=%b busy_done=%b, want 21/1/0",
                         vin[i], edges, b0, bd);
            end
            checks++;
            if (bin !== vexp[i] || err !== 1'b0 || ovf !== vovf[i]) begin
                failures++;
                $display("FAIL conv_result[%h]: got bin=%h err=%b ovf=%b, want bin=%h err=0 ovf=%b",
                         vin[i], bin, err, ovf, vexp[i], vovf[i]);
            end
            if (i == 0) begin
                @(posedge i_clk);
                #1;
                checks++;
                if (o_done !== 1'b0 || o_busy !== 1'b0 || o_binary !== 16'h3039) begin
                    failures++;
                    $display("FAIL done_pulse_width: got done=%b busy=%b bin=%h, want 0/0/3039",
                             o_done, o_busy, o_binary);
                end
            end
        end
    endtask

    task automatic test_error();
        int edges; logic [15:0] bin; logic err, ovf, b0, bd;
        run_conv(20'h1A345, edges, bin, err, ovf, b0, bd);
        checks++;
        if (edges !== 1 || b0 !== 1'b1 || bd !== 1'b0) begin
            failures++;
            $display("FAIL err_timing: got edges=%0d busy0=%b busy_done=%b, want 1/1/0",
                     edges, b0, bd);
        end
        checks++;
        if (bin !== 16'h0 || err !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL err_result: got bin=%h err=%b ovf=%b, want 0000/1/0", bin, err, ovf);
        end
        // A good conversion afterwards must clear the sticky error flag.
        run_conv(20'h00007, edges, bin, err, ovf, b0, bd);
        checks++;
        if (bin !== 16'h0007 || err !== 1'b0 || edges !== 21) begin
            failures++;
            $display("FAIL err_clears: got bin=%h err=%b edges=%0d, want 0007/0/21", bin, err, edges);
        end
    endtask

    task automatic test_busy_ignore();
        int edges = 0;
        int ndone = 0;
        int first = -1;
        @(negedge i_clk);
        i_start = 1'b1;
        i_bcd   = 20'h12345;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        while (edges < 30) begin
            if (edges == 4) begin
                i_start = 1'b1;
                i_bcd   = 20'h00001;
            end else begin
                i_start = 1'b0;
            end
            @(posedge i_clk);
            #1;
            edges++;
            if (o_done) begin
                ndone++;
                if (first < 0) first = edges;
            end
        end
        i_start = 1'b0;
        checks++;
        if (ndone !== 1 || first !== 21 || o_binary !== 16'h3039) begin
            failures++;
            $display("FAIL busy_ignore: got ndone=%0d first=%0d bin=%h, want 1/21/3039",
                     ndone, first, o_binary);
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        int edges; logic [15:0] bin; logic err, ovf, b0, bd;
        // Leave ovf=1 behind so the reset has something to clear.
        run_conv(20'h99999, edges, bin, err, ovf, b0, bd);
        @(negedge i_clk);
        i_start = 1'b1;
        i_bcd   = 20'h12345;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (9) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        checks++;
        if ({o_busy, o_done, o_binary, o_err, o_ovf} !== 20'h0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b done=%b bin=%h err=%b ovf=%b, want all 0",
                     o_busy, o_done, o_binary, o_err, o_ovf);
        end
        repeat (25) begin
            @(posedge i_clk);
            #1;
            if (o_done) ndone++;
        end
        checks++;
        if (ndone !== 0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: got ndone=%0d busy=%b, want 0/0", ndone, o_busy);
        end
        run_conv(20'h00042, edges, bin, err, ovf, b0, bd);
        checks++;
        if (bin !== 16'h002A || edges !== 21 || err !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_fresh: got bin=%h edges=%0d err=%b ovf=%b, want 002A/21/0/0",
                     bin, edges, err, ovf);
        end
    endtask

    task automatic test_back_to_back();
        int edges = 0;
        int d1 = -1;
        int d2 = -1;
        logic busy_after = 1'b0;
        logic [15:0] bin1 = '0;
        @(negedge i_clk);
        i_start = 1'b1;
        i_bcd   = 20'h00100;
        @(posedge i_clk);
        #1;
        while (d2 < 0 && edges < 60) begin
            @(posedge i_clk);
            #1;
            edges++;
            if (d1 > 0 && edges == d1 + 1) busy_after = o_busy;
            if (o_done) begin
                if (d1 < 0) begin
                    d1   = edges;
                    bin1 = o_binary;
                end else begin
                    d2 = edges;
                end
            end
        end
        i_start = 1'b0;
        checks++;
        if (d1 !== 21 || d2 !== 43) begin
            failures++;
            $display("FAIL b2b_spacing: got done at %0d and %0d, want 21 and 43", d1, d2);
        end
        checks++;
        if (busy_after !== 1'b1 || bin1 !== 16'h0064 || o_binary !== 16'h0064) begin
            failures++;
            $display("FAIL b2b_result: got busy_after=%b bin1=%h bin2=%h, want 1/0064/0064",
                     busy_after, bin1, o_binary);
        end
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: got busy=%b done=%b after start dropped, want 0/0",
                     o_busy, o_done);
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_error();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
